// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/JUMP/HALT control with a two-cycle taken-jump
// through an external target lookup table.
// Optional feature macro: PC_RETURN_STACK_EN adds a 4-entry call/return stack.
module pc_sequencer #(
    parameter int unsigned D           = 12,
    parameter int unsigned NUM_TARGETS = 10
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Stall,
    input  logic         BranchEn,
    input  logic         Taken,
    input  logic [3:0]   LutIdx,
    input  logic [D-1:0] Target,
    input  logic         Halt,
    input  logic         Call,
    input  logic         Ret,
    output logic [2:0]   Addr,
    output logic         ThirdBit,
    output logic [D-1:0] PC,
    output logic         Running,
    output logic         Done,
    output logic         BadIdx,
    output logic         StackErr
);

    localparam int unsigned LUT_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, JUMP, HALT} state_e;

    state_e             state_q, state_d;
    logic [D-1:0]       pc_q, pc_d;
    logic [LUT_W-1:0]   lut_q, lut_d;
    logic               bad_q, bad_d;
    logic               running_q, running_d;
    logic               done_q, done_d;
    logic [D-1:0]       pc_inc_c;
    logic               idx_ok_c;
    logic               jump_req_c;

`ifdef PC_RETURN_STACK_EN
    localparam int unsigned STK_DEPTH = 4;
    localparam int unsigned CNT_W     = 3;

    // Entry 0 is the top of stack; pushing shifts toward the bottom so a
    // push into a full stack naturally discards the oldest entry.
    logic [STK_DEPTH-1:0][D-1:0] stk_q, stk_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        serr_q, serr_d;
`else
    logic unused_call_ret;
    assign unused_call_ret = Call ^ Ret;
`endif

    assign pc_inc_c   = pc_q + D'(1);
    assign idx_ok_c   = (32'(LutIdx) < NUM_TARGETS);
    assign jump_req_c = BranchEn && Taken;

    // State and datapath registers; reset abandons any jump in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            lut_q     <= '0;
            bad_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef PC_RETURN_STACK_EN
            stk_q     <= '0;
            cnt_q     <= '0;
            serr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            lut_q     <= lut_d;
            bad_q     <= bad_d;
            running_q <= running_d;
            done_q    <= done_d;
`ifdef PC_RETURN_STACK_EN
            stk_q     <= stk_d;
            cnt_q     <= cnt_d;
            serr_q    <= serr_d;
`endif
        end
    end

    // Next-state, next-PC and status decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lut_d   = lut_q;
        bad_d   = 1'b0;
`ifdef PC_RETURN_STACK_EN
        stk_d   = stk_q;
        cnt_d   = cnt_q;
        serr_d  = serr_q;
`endif
        case (state_q)
            IDLE: begin
                pc_d = '0;
                if (Start) begin
                    state_d = RUN;
`ifdef PC_RETURN_STACK_EN
                    serr_d  = 1'b0;
`endif
                end
            end
            RUN: begin
                if (Halt) begin
                    state_d = HALT;
                end else if (Stall) begin
                    state_d = RUN;
                end else if (jump_req_c && idx_ok_c) begin
                    lut_d   = LutIdx;
                    state_d = JUMP;
`ifdef PC_RETURN_STACK_EN
                    if (Call) begin
                        for (int i = STK_DEPTH - 1; i > 0; i--) begin
                            stk_d[i] = stk_q[i-1];
                        end
                        stk_d[0] = pc_inc_c;
                        if (cnt_q == CNT_W'(STK_DEPTH)) begin
                            serr_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
`endif
                end else if (jump_req_c) begin
                    pc_d  = pc_inc_c;
                    bad_d = 1'b1;
                end
`ifdef PC_RETURN_STACK_EN
                else if (Ret) begin
                    if (cnt_q == '0) begin
                        pc_d   = pc_inc_c;
                        serr_d = 1'b1;
                    end else begin
                        pc_d = stk_q[0];
                        for (int i = 0; i < STK_DEPTH - 1; i++) begin
                            stk_d[i] = stk_q[i+1];
                        end
                        stk_d[STK_DEPTH-1] = '0;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`endif
                else begin
                    pc_d = pc_inc_c;
                end
            end
            JUMP: begin
                pc_d    = Target;
                state_d = Halt ? HALT : RUN;
            end
            HALT: begin
                if (Start) begin
                    pc_d    = '0;
                    state_d = RUN;
`ifdef PC_RETURN_STACK_EN
                    serr_d  = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN) || (state_d == JUMP);
        done_d    = (state_d == HALT);
    end

    assign Addr     = lut_q[2:0];
    assign ThirdBit = lut_q[3];
    assign PC       = pc_q;
    assign Running  = running_q;
    assign Done     = done_q;
    assign BadIdx   = bad_q;
`ifdef PC_RETURN_STACK_EN
    assign StackErr = serr_q;
`else
    assign StackErr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected outputs, a
// negedge monitor pops and compares. Stack checks run when PC_RETURN_STACK_EN is defined.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        Start = 1'b0, Stall = 1'b0, BranchEn = 1'b0, Taken = 1'b0;
    logic        Halt = 1'b0, Call = 1'b0, Ret = 1'b0;
    logic [3:0]  LutIdx = 4'd0;
    logic [11:0] Target;
    logic [2:0]  Addr;
    logic        ThirdBit, Running, Done, BadIdx, StackErr;
    logic [11:0] PC;

    logic [11:0] lut_mem [16];

    typedef struct {
        string       name;
        logic [11:0] pc;
        logic        run;
        logic        done;
        logic        bad;
        logic [3:0]  lut;
        logic        serr;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass = 0;

    pc_sequencer dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .Taken(Taken), .LutIdx(LutIdx), .Target(Target),
        .Halt(Halt), .Call(Call), .Ret(Ret), .Addr(Addr), .ThirdBit(ThirdBit),
        .PC(PC), .Running(Running), .Done(Done), .BadIdx(BadIdx), .StackErr(StackErr)
    );

    always #5 Clk = ~Clk;

    // Target lookup table model driven from the registered index
    assign Target = lut_mem[{ThirdBit, Addr}];

    // Monitor: compare the DUT against the oldest pending expectation
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if ({PC, Running, Done, BadIdx, ThirdBit, Addr, StackErr} !==
                {e.pc, e.run, e.done, e.bad, e.lut, e.serr}) begin
                $display("FAIL %s: got PC=%0d Run=%b Done=%b Bad=%b Idx=%0d SErr=%b, want PC=%0d Run=%b Done=%b Bad=%b Idx=%0d SErr=%b",
                         e.name, PC, Running, Done, BadIdx, {ThirdBit, Addr}, StackErr,
                         e.pc, e.run, e.done, e.bad, e.lut, e.serr);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int pc, input logic run, input logic done,
                              input logic bad, input logic [3:0] lut, input logic serr);
        exp_t x;
        x.name = nm; x.pc = 12'(pc); x.run = run; x.done = done;
        x.bad = bad; x.lut = lut; x.serr = serr;
        q.push_back(x);
        @(negedge Clk);
        #1;
    endtask

    task automatic take(input logic [3:0] idx);
        BranchEn = 1'b1; Taken = 1'b1; LutIdx = idx;
    endtask

    task automatic clear_br();
        BranchEn = 1'b0; Taken = 1'b0; LutIdx = 4'd0; Call = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) lut_mem[i] = 12'd0;
        lut_mem[1] = 12'd7;
        lut_mem[3] = 12'd4094;
        lut_mem[4] = 12'd102;
        lut_mem[5] = 12'd52;
        lut_mem[9] = 12'd400;

        // Reset and idle until Start
        #1 Reset_n = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        tick(); expect_out("idle0", 0, 0, 0, 0, 0, 0);
        tick(); expect_out("idle1", 0, 0, 0, 0, 0, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("start", 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick(); expect_out("count", i, 1, 0, 0, 0, 0);
        end

        // Taken jump from 20 via index 4; Stall during JUMP is ignored
        take(4'd4); tick(); clear_br(); Stall = 1'b1;
        expect_out("jreq", 20, 1, 0, 0, 4, 0);
        tick(); Stall = 1'b0;
        expect_out("jload", 102, 1, 0, 0, 4, 0);
        tick(); expect_out("jnext", 103, 1, 0, 0, 4, 0);

        // Reach PC 7, then invalid index and not-taken branch
        take(4'd1); tick(); clear_br();
        expect_out("j7req", 103, 1, 0, 0, 1, 0);
        tick(); expect_out("j7load", 7, 1, 0, 0, 1, 0);
        take(4'd12); tick();
        Taken = 1'b0; LutIdx = 4'd9;
        expect_out("badidx", 8, 1, 0, 1, 1, 0);
        tick(); clear_br();
        expect_out("nottaken", 9, 1, 0, 0, 1, 0);

        // Stall holds PC and masks a taken jump
        Stall = 1'b1; take(4'd2); tick();
        Stall = 1'b0; clear_br();
        expect_out("stall", 9, 1, 0, 0, 1, 0);
        tick(); expect_out("unstall", 10, 1, 0, 0, 1, 0);

        // Wrap past 4095
        take(4'd3); tick(); clear_br();
        expect_out("j3req", 10, 1, 0, 0, 3, 0);
        tick(); expect_out("j4094", 4094, 1, 0, 0, 3, 0);
        tick(); expect_out("pc4095", 4095, 1, 0, 0, 3, 0);
        tick(); expect_out("wrap", 0, 1, 0, 0, 3, 0);
        tick(); expect_out("pc1", 1, 1, 0, 0, 3, 0);

        // Halt wins over a taken jump; Start restarts from 0
        Halt = 1'b1; take(4'd4); tick(); Halt = 1'b0; clear_br();
        expect_out("halt", 1, 0, 1, 0, 3, 0);
        tick(); expect_out("haltheld", 1, 0, 1, 0, 3, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("restart", 0, 1, 0, 0, 3, 0);
        tick(); expect_out("rpc1", 1, 1, 0, 0, 3, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("startinrun", 2, 1, 0, 0, 3, 0);

        // Halt during JUMP still loads Target
        take(4'd4); tick(); clear_br(); Halt = 1'b1;
        expect_out("j4req", 2, 1, 0, 0, 4, 0);
        tick(); Halt = 1'b0;
        expect_out("jumphalt", 102, 0, 1, 0, 4, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("restart2", 0, 1, 0, 0, 4, 0);

        // Reset in the middle of a jump abandons it
        take(4'd9); tick(); clear_br();
        expect_out("j9req", 0, 1, 0, 0, 9, 0);
        Reset_n = 1'b0;
        expect_out("rstjump", 0, 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
        tick(); expect_out("noload", 0, 0, 0, 0, 0, 0);
        tick(); expect_out("noload2", 0, 0, 0, 0, 0, 0);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("start3", 0, 1, 0, 0, 0, 0);

`ifdef PC_RETURN_STACK_EN
        for (int i = 1; i <= 10; i++) begin
            tick(); expect_out("scount", i, 1, 0, 0, 0, 0);
        end
        take(4'd5); Call = 1'b1; tick(); clear_br();
        expect_out("call", 10, 1, 0, 0, 5, 0);
        tick(); expect_out("calltgt", 52, 1, 0, 0, 5, 0);
        Ret = 1'b1; tick(); Ret = 1'b0;
        expect_out("ret", 11, 1, 0, 0, 5, 0);
        for (int k = 1; k <= 5; k++) begin
            take(4'd5); Call = 1'b1; tick(); clear_br();
            expect_out("ncall", (k == 1) ? 11 : 52, 1, 0, 0, 5, (k == 5));
            tick(); expect_out("ncalltgt", 52, 1, 0, 0, 5, (k == 5));
        end
        for (int k = 1; k <= 4; k++) begin
            Ret = 1'b1; tick(); Ret = 1'b0;
            expect_out("pop", 53, 1, 0, 0, 5, 1);
        end
        Ret = 1'b1; tick(); Ret = 1'b0;
        expect_out("popempty", 54, 1, 0, 0, 5, 1);
        Halt = 1'b1; tick(); Halt = 1'b0;
        expect_out("shalt", 54, 0, 1, 0, 5, 1);
        Start = 1'b1; tick(); Start = 1'b0;
        expect_out("serrclr", 0, 1, 0, 0, 5, 0);
        Ret = 1'b1; tick(); Ret = 1'b0;
        expect_out("emptyret", 1, 1, 0, 0, 5, 1);
`endif

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge Clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter D, default 12: PC and target width.
REQ-002 SHALL have parameter NUM_TARGETS, default 10: valid jump-index count; index >= NUM_TARGETS is invalid.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Start  input  1  begin execution from PC 0.
REQ-006 SHALL have port Stall  input  1  hold PC this cycle.
REQ-007 SHALL have port BranchEn  input  1  current instruction is a jump.
REQ-008 SHALL have port Taken  input  1  jump condition true.
REQ-009 SHALL have port LutIdx  input  4  jump-target index from the instruction.
REQ-010 SHALL have port Target  input  D  jump target returned by the target lookup table.
REQ-011 SHALL have port Halt  input  1  done instruction executed.
REQ-012 SHALL have port Call, Ret  input  1 each  subroutine call / return (used only with REQ-033).
REQ-013 SHALL have port Addr  output  3  registered LutIdx[2:0] to the lookup table.
REQ-014 SHALL have port ThirdBit  output  1  registered LutIdx[3] to the lookup table.
REQ-015 SHALL have port PC  output  D  current instruction address.
REQ-016 SHALL have ports Running, Done, BadIdx, StackErr  output  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, RUN, JUMP, HALT; Running=1 only in RUN and JUMP; Done=1 only in HALT.
REQ-018 IDLE: PC held at 0; Start -> RUN next edge; other inputs ignored.
REQ-019 RUN priority SHALL be Halt > Stall > taken jump > increment.
REQ-020 RUN, Halt=1: PC held, -> HALT.
REQ-021 RUN, Stall=1 (no Halt): PC, state, Addr/ThirdBit held.
REQ-022 RUN, BranchEn=1 and Taken=1, LutIdx < NUM_TARGETS: {ThirdBit,Addr}<=LutIdx, PC held, -> JUMP.
REQ-023 RUN, BranchEn=1 and Taken=1, LutIdx >= NUM_TARGETS: no jump, PC<=PC+1, BadIdx pulses 1 for exactly one cycle.
REQ-024 RUN, otherwise (incl. BranchEn=1, Taken=0): PC<=(PC+1) mod 2^D; D'hFFF wraps to 0 with no flag.
REQ-025 JUMP: PC<=Target (sampled this cycle, after Addr/ThirdBit registered); Stall ignored; -> RUN, or -> HALT if Halt=1.
REQ-026 Taken jump latency SHALL be 2 cycles: request edge, then Target-load edge; PC holds one bubble cycle.
REQ-027 HALT: PC and Done held; Start -> PC<=0, Done<=0, -> RUN.
REQ-028 Start in RUN or JUMP SHALL be ignored.
REQ-029 BranchEn, Taken, LutIdx SHALL be ignored while Stall=1 or Halt=1.

Reset
REQ-030 Reset_n=0 SHALL immediately force PC=0, Addr=0, ThirdBit=0, state IDLE, Running=0, Done=0, BadIdx=0, StackErr=0, return stack empty.
REQ-031 Reset asserted mid-JUMP SHALL abandon the jump; no Target load after release.
REQ-032 After Reset_n rises, block SHALL remain in IDLE until Start.

Configuration
REQ-033 With PC_RETURN_STACK_EN defined: 4-entry return stack; taken jump with Call=1 pushes PC+1; in RUN, Ret=1 (no Halt/Stall/jump) pops into PC, 1-cycle latency.
REQ-034 With PC_RETURN_STACK_EN: push when full drops oldest entry and sets StackErr; pop when empty gives PC<=PC+1 and sets StackErr; StackErr sticky until reset or Start.
REQ-035 Without PC_RETURN_STACK_EN: Call and Ret ignored, StackErr tied 0, no stack storage.

Verification
REQ-036 Reset, Start, 5 plain cycles -> PC 0,1,2,3,4,5; Running=1, Done=0.
REQ-037 At PC=20, BranchEn=1 Taken=1 LutIdx=4, Target=102 -> Addr=4 ThirdBit=0, PC 20 held one cycle, then PC=102, then 103.
REQ-038 At PC=7, LutIdx=12 taken -> PC=8, BadIdx one-cycle pulse, Addr unchanged; LutIdx=9 Taken=0 -> PC=9.
REQ-039 PC=4095, no jump -> PC=0; Halt and taken jump same cycle -> HALT, PC held, Done=1; Start -> PC=0, RUN.
REQ-040 Reset_n low during JUMP (Target=400) -> PC=0, IDLE immediately; no load of 400 after release.
REQ-041 With PC_RETURN_STACK_EN: call from PC=10 to 52, Ret -> PC=11; 5 nested calls -> StackErr=1; Ret on empty stack -> PC+1, StackErr=1.
